// File: rtl/mvu_sched_pkg.sv
// mvu_sched_pkg: shared types and helpers for the MVU fold scheduler.
//   state_t - scheduler phase: FILL (fold 0, activations streamed in) or
//             REPLAY (later folds, activations replayed from the buffer)
//   cnt_w   - bit width for a counter that runs 0..n-1 (never less than 1)
package mvu_sched_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvu_sched_fifo.sv
// mvu_sched_fifo: first-word-fall-through result FIFO.
//   clk, rst (async, active-low)
//   push/din  - write side; a push while full is accepted only together with a pop
//   pop/dout  - read side; dout always shows the oldest entry
//   empty, full
module mvu_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage carries no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mvu_fold_scheduler.sv
// mvu_fold_scheduler: folds an MH x MW matrix-vector product onto a PE x SIMD core.
//   clk, rst (async, active-low)
//   s_act_*  - activation beats, consumed only during fold 0 (FILL)
//   s_wgt_*  - weight beats, one per core step
//   core_*   - drive/return of the external MAC core; core_en freezes its pipeline
//   m_*      - per-fold result stream through an output FIFO
//   perf_*   - bubble/stall counters, present only with MVU_FOLD_SCHEDULER_PERF_EN
module mvu_fold_scheduler
    import mvu_sched_pkg::*;
#(
    parameter int MH               = 32,
    parameter int MW               = 120,
    parameter int PE               = 16,
    parameter int SIMD             = 60,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int WEIGHT_WIDTH     = 4,
    parameter int ACCU_WIDTH       = 58,
    parameter int OUT_DEPTH        = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [SIMD*ACTIVATION_WIDTH-1:0]   s_act_tdata,
    input  logic                               s_act_tvalid,
    output logic                               s_act_tready,
    input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]    s_wgt_tdata,
    input  logic                               s_wgt_tvalid,
    output logic                               s_wgt_tready,
    output logic                               core_en,
    output logic                               core_last,
    output logic                               core_zero,
    output logic [SIMD*ACTIVATION_WIDTH-1:0]   core_a,
    output logic [PE*SIMD*WEIGHT_WIDTH-1:0]    core_w,
    input  logic                               core_vld,
    input  logic [PE*ACCU_WIDTH-1:0]           core_p,
    output logic [PE*ACCU_WIDTH-1:0]           m_tdata,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [31:0]                        perf_bubble_cnt,
    output logic [31:0]                        perf_stall_cnt
);

    localparam int SF  = MW / SIMD;
    localparam int NF  = MH / PE;
    localparam int SFW = cnt_w(SF);
    localparam int NFW = cnt_w(NF);
    localparam int AB  = SIMD * ACTIVATION_WIDTH;

    if (MW % SIMD != 0 || MH % PE != 0) begin : g_bad_fold
        $error("mvu_fold_scheduler: MW must divide by SIMD and MH by PE");
    end

    state_t         state, state_nx;
    logic [SFW-1:0] sf, sf_nx;
    logic [NFW-1:0] nf, nf_nx;
    logic           fire, fifo_full, fifo_empty, last_sf, last_nf;
    logic [AB-1:0]  buffer [SF];

    assign last_sf = (sf == SFW'(SF - 1));
    assign last_nf = (nf == NFW'(NF - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
            sf    <= '0;
            nf    <= '0;
        end else begin
            state <= state_nx;
            sf    <= sf_nx;
            nf    <= nf_nx;
        end
    end

    // the last beat of the last fold returns to FILL; with NF==1 last_nf is
    // always true, so REPLAY is never entered
    always_comb begin
        state_nx = state;
        sf_nx    = sf;
        nf_nx    = nf;
        if (fire) begin
            sf_nx = last_sf ? '0 : sf + SFW'(1);
            if (last_sf) begin
                nf_nx    = last_nf ? '0 : nf + NFW'(1);
                state_nx = last_nf ? FILL : REPLAY;
            end
        end
    end

    // rst gates core_en so readies and core enable are low throughout reset
    always_comb begin
        core_en      = rst && !fifo_full;
        fire         = core_en && s_wgt_tvalid && (state == REPLAY || s_act_tvalid);
        s_wgt_tready = fire;
        s_act_tready = fire && state == FILL;
        core_zero    = !fire;
        core_last    = fire && last_sf;
        core_a       = (state == FILL) ? s_act_tdata : buffer[sf];
        core_w       = s_wgt_tdata;
    end

    // replay buffer holds the current vector; deliberately not reset
    always_ff @(posedge clk) begin
        if (fire && state == FILL) buffer[sf] <= s_act_tdata;
    end

    mvu_sched_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (PE * ACCU_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (core_vld && core_en),
        .din   (core_p),
        .pop   (m_tready),
        .dout  (m_tdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_tvalid = !fifo_empty;

`ifdef MVU_FOLD_SCHEDULER_PERF_EN
    logic [31:0] bubble_q, stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (core_en && !fire && !(&bubble_q)) bubble_q <= bubble_q + 32'd1;
            if (!core_en && !(&stall_q))          stall_q  <= stall_q + 32'd1;
        end
    end

    assign perf_bubble_cnt = bubble_q;
    assign perf_stall_cnt  = stall_q;
`else
    assign perf_bubble_cnt = '0;
    assign perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mvu_fold_scheduler.sv
// tb_mvu_fold_scheduler: randomized bench with a behavioural fold/FIFO model and golden matrix-vector products.
module tb_mvu_fold_scheduler;

    localparam int MH    = 32;
    localparam int MW    = 120;
    localparam int PE    = 16;
    localparam int SIMD  = 60;
    localparam int AW    = 8;
    localparam int WW    = 4;
    localparam int ACCU  = 58;
    localparam int DEPTH = 4;
    localparam int SF    = MW / SIMD;
    localparam int NF    = MH / PE;
    localparam int AB    = SIMD * AW;
    localparam int WB    = PE * SIMD * WW;
    localparam int PB    = PE * ACCU;

    typedef logic [AB-1:0] abeat_t;
    typedef logic [WB-1:0] wbeat_t;
    typedef logic [PB-1:0] pbeat_t;

    logic        clk = 0;
    logic        rst = 0;
    abeat_t      s_act_tdata = '0;
    logic        s_act_tvalid = 0;
    logic        s_act_tready;
    wbeat_t      s_wgt_tdata = '0;
    logic        s_wgt_tvalid = 0;
    logic        s_wgt_tready;
    logic        core_en, core_last, core_zero;
    abeat_t      core_a;
    wbeat_t      core_w;
    logic        core_vld = 0;
    pbeat_t      core_p = '0;
    pbeat_t      m_tdata;
    logic        m_tvalid;
    logic        m_tready = 0;
    logic [31:0] perf_bubble_cnt, perf_stall_cnt;

    mvu_fold_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .s_act_tdata     (s_act_tdata),
        .s_act_tvalid    (s_act_tvalid),
        .s_act_tready    (s_act_tready),
        .s_wgt_tdata     (s_wgt_tdata),
        .s_wgt_tvalid    (s_wgt_tvalid),
        .s_wgt_tready    (s_wgt_tready),
        .core_en         (core_en),
        .core_last       (core_last),
        .core_zero       (core_zero),
        .core_a          (core_a),
        .core_w          (core_w),
        .core_vld        (core_vld),
        .core_p          (core_p),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    abeat_t act_q[$];
    wbeat_t wgt_q[$];
    pbeat_t exp_q[$];
    pbeat_t fifo_m[$];
    pbeat_t res_log[$];
    abeat_t rec_a[$];
    logic   rec_l[$];
    logic   rec_r[$];
    abeat_t abuf[SF];
    int     acc[PE];

    int          k = 0;
    logic [31:0] bub_m = 0, stl_m = 0;
    logic        rst_drv = 0, wgt_hold = 0, vld_n = 0, last_ce = 0;
    pbeat_t      p_n = '0;
    int          act_p = 100, wgt_p = 100, rdy_p = 100;
    logic        rec_en = 0, zwin = 0, post_chk = 0;
    int          zcnt = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic chkw(input string n, input logic [WB-1:0] a, input logic [WB-1:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got(low)=%h exp(low)=%h t=%0t", n, a[255:0], e[255:0], $time);
        end
    endtask

    // builds one random (or hand-picked) vector and matrix, queues its beats and golden per-fold results
    task automatic gen_vector(input logic lit);
        int     x[MW];
        int     w[MH][MW];
        abeat_t a;
        wbeat_t wb;
        pbeat_t r;
        int     sum;
        for (int c = 0; c < MW; c++) x[c] = lit ? (c < SIMD ? 1 : 2) : int'($urandom_range(255));
        for (int row = 0; row < MH; row++)
            for (int c = 0; c < MW; c++) w[row][c] = lit ? (row < PE ? 1 : 2) : int'($urandom_range(15));
        for (int f = 0; f < SF; f++) begin
            for (int s = 0; s < SIMD; s++) a[s*AW +: AW] = AW'(x[f*SIMD+s]);
            act_q.push_back(a);
        end
        for (int n = 0; n < NF; n++)
            for (int f = 0; f < SF; f++) begin
                for (int pe = 0; pe < PE; pe++)
                    for (int s = 0; s < SIMD; s++) wb[(pe*SIMD+s)*WW +: WW] = WW'(w[n*PE+pe][f*SIMD+s]);
                wgt_q.push_back(wb);
            end
        for (int n = 0; n < NF; n++) begin
            for (int pe = 0; pe < PE; pe++) begin
                sum = 0;
                for (int c = 0; c < MW; c++) sum += x[c] * w[n*PE+pe][c];
                r[pe*ACCU +: ACCU] = ACCU'(sum);
            end
            exp_q.push_back(r);
        end
    endtask

    // one clock: drive at negedge, check everything against the model, then advance the model
    task automatic cycle();
        logic ce_e, fire_e, push, pop;
        int   fold, fs, dot;
        @(negedge clk);
        rst          = rst_drv;
        core_vld     = vld_n;
        core_p       = p_n;
        s_act_tvalid = act_q.size() > 0 && $urandom_range(99) < act_p;
        s_act_tdata  = act_q.size() > 0 ? act_q[0] : '0;
        s_wgt_tvalid = !wgt_hold && wgt_q.size() > 0 && $urandom_range(99) < wgt_p;
        s_wgt_tdata  = wgt_q.size() > 0 ? wgt_q[0] : '0;
        m_tready     = $urandom_range(99) < rdy_p;
        #1;
        if (!rst) begin
            k = 0;
            fifo_m.delete();
            bub_m = 0;
            stl_m = 0;
            for (int pe = 0; pe < PE; pe++) acc[pe] = 0;
            core_vld = 0;
            vld_n    = 0;
        end
        fold   = k / SF;
        fs     = k % SF;
        ce_e   = rst && fifo_m.size() < DEPTH;
        fire_e = ce_e && s_wgt_tvalid && (fold > 0 || s_act_tvalid);
        chk("core_en", core_en, ce_e);
        chk("wgt_ready", s_wgt_tready, fire_e);
        chk("act_ready", s_act_tready, fire_e && fold == 0);
        chk("core_zero", core_zero, !fire_e);
        chk("core_last", core_last, fire_e && fs == SF - 1);
        chkw("core_a", core_a, fold == 0 ? s_act_tdata : abuf[fs]);
        chkw("core_w", core_w, s_wgt_tdata);
        chk("m_tvalid", m_tvalid, fifo_m.size() > 0);
        if (fifo_m.size() > 0) chkw("m_tdata", m_tdata, fifo_m[0]);
`ifdef MVU_FOLD_SCHEDULER_PERF_EN
        chk("perf_bubble", perf_bubble_cnt, bub_m);
        chk("perf_stall", perf_stall_cnt, stl_m);
`else
        chk("perf_bubble_off", perf_bubble_cnt, 0);
        chk("perf_stall_off", perf_stall_cnt, 0);
`endif
        push = core_vld && ce_e;
        pop  = fifo_m.size() > 0 && m_tready;
        if (pop) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL result_extra got=%h exp=none t=%0t", m_tdata[63:0], $time);
            end else chkw("result", m_tdata, exp_q.pop_front());
            res_log.push_back(m_tdata);
            void'(fifo_m.pop_front());
        end
        if (push) fifo_m.push_back(core_p);
        if (rst && ce_e && !fire_e) bub_m++;
        if (rst && !ce_e) stl_m++;
        if (zwin && rst && core_zero && !core_last) zcnt++;
        if (rec_en && fire_e) begin
            rec_a.push_back(core_a);
            rec_l.push_back(core_last);
            rec_r.push_back(s_act_tready);
        end
        if (post_chk && fire_e) begin
            chk("post_reset_act_ready", s_act_tready, 1);
            post_chk = 0;
        end
        vld_n = core_vld;
        p_n   = core_p;
        if (core_en) begin
            vld_n = 0;
            if (!core_zero) begin
                for (int pe = 0; pe < PE; pe++) begin
                    dot = 0;
                    for (int s = 0; s < SIMD; s++)
                        dot += int'(core_a[s*AW +: AW]) * int'(core_w[(pe*SIMD+s)*WW +: WW]);
                    acc[pe] += dot;
                end
                if (core_last) begin
                    for (int pe = 0; pe < PE; pe++) begin
                        p_n[pe*ACCU +: ACCU] = ACCU'(acc[pe]);
                        acc[pe] = 0;
                    end
                    vld_n = 1;
                end
            end
        end
        if (fire_e) begin
            if (fold == 0) begin
                abuf[fs] = s_act_tdata;
                void'(act_q.pop_front());
            end
            void'(wgt_q.pop_front());
            k = (k + 1) % (SF * NF);
        end
        last_ce = core_en;
    endtask

    task automatic run_idle(input string n, input int max);
        int c = 0;
        while ((act_q.size() > 0 || wgt_q.size() > 0 || exp_q.size() > 0 || fifo_m.size() > 0) && c < max) begin
            cycle();
            c++;
        end
        if (c >= max) chk({n, "_timeout"}, c, 0);
    endtask

    task automatic wait_k(input string n, input int target, input int max);
        int c = 0;
        while (k != target && c < max) begin
            cycle();
            c++;
        end
        if (c >= max) chk({n, "_timeout"}, c, 0);
    endtask

    initial begin
        abeat_t      a0, a1;
        pbeat_t      t;
        logic [31:0] p0;
        int          c, ones;
        for (int pe = 0; pe < PE; pe++) acc[pe] = 0;
        repeat (2) cycle();
        rst_drv = 1;
        cycle();

        // hand-checked vector: A0 all 1, A1 all 2, fold-0 weights 1, fold-1 weights 2
        res_log.delete();
        gen_vector(1);
        rec_en = 1;
        run_idle("s1", 200);
        rec_en = 0;
        for (int s = 0; s < SIMD; s++) begin
            a0[s*AW +: AW] = AW'(1);
            a1[s*AW +: AW] = AW'(2);
        end
        chk("s1_fires", rec_a.size(), 4);
        if (rec_a.size() == 4) begin
            ones = 0;
            foreach (rec_r[i]) ones += int'(rec_r[i]);
            chk("s1_act_ready_count", ones, 2);
            chk("s1_act_ready_first", {rec_r[0], rec_r[1]}, 2'b11);
            chkw("s1_core_a0", rec_a[0], a0);
            chkw("s1_core_a1", rec_a[1], a1);
            chkw("s1_core_a2", rec_a[2], a0);
            chkw("s1_core_a3", rec_a[3], a1);
            chk("s1_core_last", {rec_l[0], rec_l[1], rec_l[2], rec_l[3]}, 4'b0101);
        end
        chk("s1_results", res_log.size(), 2);
        if (res_log.size() == 2) begin
            t = res_log[0];
            chk("s1_res0_pe0", t[ACCU-1:0], 180);
            chk("s1_res0_pelast", t[(PE-1)*ACCU +: ACCU], 180);
            t = res_log[1];
            chk("s1_res1_pe0", t[ACCU-1:0], 360);
            chk("s1_res1_pelast", t[(PE-1)*ACCU +: ACCU], 360);
        end

        // three weight bubbles in the middle of REPLAY
        gen_vector(0);
        wait_k("s2_reach", SF, 100);
        p0   = perf_bubble_cnt;
        zcnt = 0;
        zwin = 1;
        wgt_hold = 1;
        repeat (3) cycle();
        wgt_hold = 0;
        wait_k("s2_done", 0, 100);
        zwin = 0;
        chk("s2_zero_cycles", zcnt, 3);
`ifdef MVU_FOLD_SCHEDULER_PERF_EN
        chk("s2_bubble_delta", perf_bubble_cnt - p0, 3);
`else
        chk("s2_bubble_off", perf_bubble_cnt, 0);
`endif
        run_idle("s2", 200);

        // back-pressure until the FIFO holds DEPTH results, then release
        rdy_p = 0;
        repeat (DEPTH / NF) gen_vector(0);
        c = 0;
        while (fifo_m.size() < DEPTH && c < 200) begin
            cycle();
            c++;
        end
        if (c >= 200) chk("s3_fill_timeout", c, 0);
        p0 = perf_stall_cnt;
        repeat (6) cycle();
        chk("s3_core_en_low", last_ce, 0);
`ifdef MVU_FOLD_SCHEDULER_PERF_EN
        chk("s3_stall_delta", perf_stall_cnt - p0, 5);
`else
        chk("s3_stall_off", perf_stall_cnt, 0);
`endif
        rdy_p = 100;
        cycle();
        chk("s3_release_hold", last_ce, 0);
        cycle();
        chk("s3_release_rise", last_ce, 1);
        run_idle("s3", 200);

        // reset in REPLAY at sf=1 discards the partial vector
        gen_vector(0);
        wait_k("s4_reach", SF + 1, 100);
        rst_drv = 0;
        cycle();
        chk("s4_core_en", core_en, 0);
        chk("s4_act_ready", s_act_tready, 0);
        chk("s4_wgt_ready", s_wgt_tready, 0);
        chk("s4_m_tvalid", m_tvalid, 0);
        act_q.delete();
        wgt_q.delete();
        exp_q.delete();
        rst_drv  = 1;
        post_chk = 1;
        gen_vector(0);
        run_idle("s4", 200);
        chk("s4_first_fire_seen", post_chk, 0);

        // randomized valid/ready over 50 vectors
        act_p = 60;
        wgt_p = 60;
        rdy_p = 50;
        repeat (50) gen_vector(0);
        run_idle("s6", 20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mvu_fold_scheduler.md
MVU_FOLD_SCHEDULER -- requirements
Module: mvu_fold_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MH, 32, matrix height
- MW, 120, matrix width
- PE, 16, output channels per fold
- SIMD, 60, inputs per beat
- ACTIVATION_WIDTH, 8, activation bits
- WEIGHT_WIDTH, 4, weight bits
- ACCU_WIDTH, 58, per-PE result bits
- OUT_DEPTH, 4, output FIFO entries (power of 2, at least 2)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- s_act_tdata  in  SIMD*ACTIVATION_WIDTH  activation beat
- s_act_tvalid / s_act_tready  in / out  1  activation handshake
- s_wgt_tdata  in  PE*SIMD*WEIGHT_WIDTH  weight beat
- s_wgt_tvalid / s_wgt_tready  in / out  1  weight handshake
- core_en, core_last, core_zero  out  1  core enable, end of accumulation, zero contribution
- core_a  out  SIMD*ACTIVATION_WIDTH  activations to core
- core_w  out  PE*SIMD*WEIGHT_WIDTH  weights to core
- core_vld  in  1  core result valid
- core_p  in  PE*ACCU_WIDTH  core result
- m_tdata  out  PE*ACCU_WIDTH  result stream
- m_tvalid / m_tready  out / in  1  result handshake
- perf_bubble_cnt, perf_stall_cnt  out  32  performance counters

Function
REQ-003 The constants SF=MW/SIMD and NF=MH/PE SHALL be used, and elaboration SHALL fail unless MW%SIMD==0 and MH%PE==0.
REQ-004 The FSM SHALL have two states: FILL (fold nf=0, activations come from the stream) and REPLAY (nf>0, activations come from the internal SF-entry buffer).
REQ-005 core_en SHALL equal !fifo_full; the core pipeline freezes whenever core_en is 0.
REQ-006 The fire condition SHALL be core_en && s_wgt_tvalid && (REPLAY || s_act_tvalid).
REQ-007 s_wgt_tready SHALL equal fire.
REQ-008 s_act_tready SHALL equal fire && FILL, and s_act_tready SHALL be 0 throughout REPLAY.
REQ-009 When fire is 1 in FILL, s_act_tdata SHALL be written into buffer[sf].
REQ-010 core_a SHALL be s_act_tdata in FILL and buffer[sf] in REPLAY.
REQ-011 core_w SHALL be s_wgt_tdata, combinationally.
REQ-012 core_zero SHALL be !fire; a bubble contributes nothing.
REQ-013 core_last SHALL be fire && sf==SF-1.
REQ-014 On fire, sf SHALL increment; at SF-1 it SHALL wrap to 0 and nf SHALL increment.
REQ-015 The FILL-to-REPLAY transition SHALL occur on the fire with sf==SF-1 and nf==0, and SHALL not occur when NF==1.
REQ-016 The transition back to FILL SHALL occur on the fire with sf==SF-1 and nf==NF-1, with nf cleared to 0.
REQ-017 When core_vld && core_en, core_p SHALL be pushed into the output FIFO; the push can never overflow because core_en is 0 when the FIFO is full.
REQ-018 The output FIFO SHALL be first-word-fall-through, and m_tvalid SHALL equal !empty.
REQ-019 Simultaneous push and pop SHALL be allowed when full, but core_en SHALL still be 0 in that cycle.
REQ-020 Results SHALL leave in the order nf=0..NF-1, vector after vector, with no loss or duplication.

Reset
REQ-021 While rst is low, the block SHALL be asynchronously forced to: state=FILL, sf=nf=0, FIFO empty, and perf counters 0.
REQ-022 While rst is low, core_en=0 and all stream readies=0.
REQ-023 Reset during REPLAY SHALL discard the partial vector; the first beat after release SHALL be treated as sf=0, nf=0 of a new vector.
REQ-024 Buffer contents SHALL not be reset.

Configuration
REQ-025 With macro MVU_FOLD_SCHEDULER_PERF_EN defined, perf_bubble_cnt SHALL count cycles with core_en && !fire, and perf_stall_cnt SHALL count cycles with !core_en; both SHALL saturate at 2^32-1.
REQ-026 Without MVU_FOLD_SCHEDULER_PERF_EN, both perf ports SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-027 A shared package mvu_sched_pkg SHALL hold the state enum (FILL, REPLAY) and the function computing the counter widths from SF and NF.
REQ-028 The output FIFO SHALL be a sub-module mvu_sched_fifo (parameters DEPTH, WIDTH; async active-low rst).

Verification
REQ-029 The bench SHALL cover the following scenarios, all with defaults (SF=2, NF=2):
- Continuous valid, m_tready=1: activations A0,A1 and weights W00,W01,W10,W11 -> s_act_tready high for exactly 2 fires; core_a sequence A0,A1,A0,A1; core_last on fires 2 and 4; 2 results pushed in order.
- Weight tvalid dropped for 3 cycles mid-REPLAY -> exactly 3 cycles with core_zero=1, core_last=0; perf_bubble_cnt=3 (macro defined); results unchanged vs golden.
- m_tready=0 until OUT_DEPTH=4 results are held -> core_en falls the cycle after the 4th push; perf_stall_cnt increments each held cycle; release with m_tready=1 -> core_en rises next cycle.
- rst low for 1 cycle during REPLAY at sf=1 -> all outputs at reset values immediately; next vector starts in FILL with s_act_tready=1 on its first fire.
- Macro undefined -> perf_bubble_cnt=perf_stall_cnt=0 under the bubble stimulus of scenario 2.
- Randomised valid/ready over 50 vectors -> every m_tdata equals the golden matrix-vector product computed per PE.
